// File: rtl/pipe_stall_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl_if
// Bundles the pipeline-control signals between the hazard detector, the
// fetch/decode datapath and pipe_stall_ctrl.
//   master : drives stall/flush/redirect and the IF/ID-stage inputs,
//            observes PC, IF/ID, ID/EX and the perf counters.
//   slave  : the controller side (pipe_stall_ctrl).
// ---------------------------------------------------------------------------
interface pipe_stall_ctrl_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
);
  logic              stall;
  logic              flush;
  logic [XLEN-1:0]   redirect_pc;
  logic [XLEN-1:0]   imem_instr;
  logic [CTRL_W-1:0] id_ctrl;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic [4:0]        id_rd;

  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   if_id_pc;
  logic [XLEN-1:0]   if_id_instr;
  logic              if_id_valid;
  logic [CTRL_W-1:0] id_ex_ctrl;
  logic [4:0]        id_ex_rs1;
  logic [4:0]        id_ex_rs2;
  logic [4:0]        id_ex_rd;
  logic              id_ex_mem_read;
  logic              id_ex_valid;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output stall, flush, redirect_pc, imem_instr, id_ctrl, id_rs1, id_rs2, id_rd,
    input  pc, if_id_pc, if_id_instr, if_id_valid, id_ex_ctrl, id_ex_rs1,
           id_ex_rs2, id_ex_rd, id_ex_mem_read, id_ex_valid, stall_cnt, flush_cnt
  );

  modport slave (
    input  stall, flush, redirect_pc, imem_instr, id_ctrl, id_rs1, id_rs2, id_rd,
    output pc, if_id_pc, if_id_instr, if_id_valid, id_ex_ctrl, id_ex_rs1,
           id_ex_rs2, id_ex_rd, id_ex_mem_read, id_ex_valid, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl
// Owns PC, IF/ID and the ID/EX control/tag slice of a 5-stage RV32I pipe.
// Stall holds PC and IF/ID and injects a bubble into ID/EX; flush redirects
// the PC and kills IF/ID and ID/EX. Flush has priority over stall.
// Also counts stall-only cycles and flush cycles (saturating).
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset
//   io_bus   pipe_stall_ctrl_if.slave (stall/flush/redirect, IF/ID-stage
//            inputs, PC/IF/ID/ID/EX outputs, perf counters)
// ---------------------------------------------------------------------------
module pipe_stall_ctrl #(
  parameter int              XLEN      = 32,
  parameter int              CTRL_W    = 8,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013,
  parameter int              CNT_W     = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  pipe_stall_ctrl_if.slave    io_bus
);

  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_if_id_pc;
  logic [XLEN-1:0]   r_if_id_instr;
  logic              r_if_id_valid;
  logic [CTRL_W-1:0] r_id_ex_ctrl;
  logic [4:0]        r_id_ex_rs1;
  logic [4:0]        r_id_ex_rs2;
  logic [4:0]        r_id_ex_rd;
  logic              r_id_ex_valid;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic              w_flush;
  logic              w_stall;
  logic [XLEN-1:0]   w_redirect;
  logic [XLEN-1:0]   w_pc_inc;

  assign w_flush    = io_bus.flush;
  // stall is ignored whenever a flush is taken on the same edge
  assign w_stall    = io_bus.stall & ~io_bus.flush;
  assign w_redirect = {io_bus.redirect_pc[XLEN-1:2], 2'b00};
  assign w_pc_inc   = r_pc + XLEN'(4);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc          <= RESET_PC;
      r_if_id_pc    <= '0;
      r_if_id_instr <= NOP_INSTR;
      r_if_id_valid <= 1'b0;
      r_id_ex_ctrl  <= '0;
      r_id_ex_rs1   <= '0;
      r_id_ex_rs2   <= '0;
      r_id_ex_rd    <= '0;
      r_id_ex_valid <= 1'b0;
    end else if (w_flush) begin
      r_pc          <= w_redirect;
      r_if_id_pc    <= '0;
      r_if_id_instr <= NOP_INSTR;
      r_if_id_valid <= 1'b0;
      r_id_ex_ctrl  <= '0;
      r_id_ex_rs1   <= '0;
      r_id_ex_rs2   <= '0;
      r_id_ex_rd    <= '0;
      r_id_ex_valid <= 1'b0;
    end else if (w_stall) begin
      // PC and IF/ID hold; one bubble per stalled cycle
      r_id_ex_ctrl  <= '0;
      r_id_ex_rs1   <= '0;
      r_id_ex_rs2   <= '0;
      r_id_ex_rd    <= '0;
      r_id_ex_valid <= 1'b0;
    end else begin
      r_pc          <= w_pc_inc;
      r_if_id_pc    <= r_pc;
      r_if_id_instr <= io_bus.imem_instr;
      r_if_id_valid <= 1'b1;
      // a dead IF/ID slot must not carry decoder control into EX
      r_id_ex_ctrl  <= r_if_id_valid ? io_bus.id_ctrl : '0;
      r_id_ex_rs1   <= io_bus.id_rs1;
      r_id_ex_rs2   <= io_bus.id_rs2;
      r_id_ex_rd    <= io_bus.id_rd;
      r_id_ex_valid <= r_if_id_valid;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign io_bus.pc             = r_pc;
  assign io_bus.if_id_pc       = r_if_id_pc;
  assign io_bus.if_id_instr    = r_if_id_instr;
  assign io_bus.if_id_valid    = r_if_id_valid;
  assign io_bus.id_ex_ctrl     = r_id_ex_ctrl;
  assign io_bus.id_ex_rs1      = r_id_ex_rs1;
  assign io_bus.id_ex_rs2      = r_id_ex_rs2;
  assign io_bus.id_ex_rd       = r_id_ex_rd;
  // MemRead bit; drops to 0 after a bubble, ending a single load-use stall
  assign io_bus.id_ex_mem_read = r_id_ex_ctrl[7];
  assign io_bus.id_ex_valid    = r_id_ex_valid;
  assign io_bus.stall_cnt      = r_stall_cnt;
  assign io_bus.flush_cnt      = r_flush_cnt;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
module tb_pipe_stall_ctrl;

  logic clk;
  logic rst_n;
  logic rst_ns;

  pipe_stall_ctrl_if #(.XLEN(32), .CTRL_W(8), .CNT_W(16)) bus ();
  pipe_stall_ctrl_if #(.XLEN(32), .CTRL_W(8), .CNT_W(4))  bus_s ();

  pipe_stall_ctrl #(.XLEN(32), .CTRL_W(8), .RESET_PC(32'h0), .NOP_INSTR(32'h13), .CNT_W(16)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus.slave)
  );

  pipe_stall_ctrl #(.XLEN(32), .CTRL_W(8), .RESET_PC(32'h0), .NOP_INSTR(32'h13), .CNT_W(4)) u_sat (
    .i_clk   (clk),
    .i_rst_n (rst_ns),
    .io_bus  (bus_s.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tot = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        stall;
    logic        flush;
    logic [31:0] redir;
    logic [31:0] instr;
    logic [7:0]  ctrl;
    logic [4:0]  rd;
    logic [31:0] e_pc;
    logic [31:0] e_ifpc;
    logic [31:0] e_instr;
    logic        e_ifv;
    logic [7:0]  e_ctrl;
    logic [4:0]  e_rd;
    logic        e_exv;
    logic        e_mr;
    logic [15:0] e_sc;
    logic [15:0] e_fc;
  } vec_t;

  vec_t vt[13];

  function automatic vec_t mk(
    input logic s, input logic f, input logic [31:0] rdr, input logic [31:0] ins,
    input logic [7:0] c, input logic [4:0] d,
    input logic [31:0] epc, input logic [31:0] eifpc, input logic [31:0] eins, input logic eifv,
    input logic [7:0] ec, input logic [4:0] erd, input logic eexv, input logic emr,
    input logic [15:0] esc, input logic [15:0] efc);
    vec_t v;
    v.stall = s; v.flush = f; v.redir = rdr; v.instr = ins; v.ctrl = c; v.rd = d;
    v.e_pc = epc; v.e_ifpc = eifpc; v.e_instr = eins; v.e_ifv = eifv;
    v.e_ctrl = ec; v.e_rd = erd; v.e_exv = eexv; v.e_mr = emr; v.e_sc = esc; v.e_fc = efc;
    return v;
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_pc"},       bus.pc, 32'h0);
    check({tag, "_ifpc"},     bus.if_id_pc, 32'h0);
    check({tag, "_ifinstr"},  bus.if_id_instr, 32'h13);
    check({tag, "_ifvalid"},  {31'h0, bus.if_id_valid}, 32'h0);
    check({tag, "_exctrl"},   {24'h0, bus.id_ex_ctrl}, 32'h0);
    check({tag, "_exrd"},     {27'h0, bus.id_ex_rd}, 32'h0);
    check({tag, "_exvalid"},  {31'h0, bus.id_ex_valid}, 32'h0);
    check({tag, "_stallcnt"}, {16'h0, bus.stall_cnt}, 32'h0);
    check({tag, "_flushcnt"}, {16'h0, bus.flush_cnt}, 32'h0);
  endtask

  initial begin
    // vectors: inputs applied before an edge, expected state after it
    //             st f  redir         instr         ctrl   rd     pc            ifpc          ifinstr       ifv ctrl   rd     exv mr sc  fc
    vt[0]  = mk(0, 0, 32'h0,        32'h00500093, 8'h22, 5'd3,  32'h4,        32'h0,        32'h00500093, 1, 8'h00, 5'd3,  0, 0, 0, 0);
    vt[1]  = mk(0, 0, 32'h0,        32'h00500093, 8'h22, 5'd4,  32'h8,        32'h4,        32'h00500093, 1, 8'h22, 5'd4,  1, 0, 0, 0);
    vt[2]  = mk(0, 0, 32'h0,        32'h11111111, 8'hA0, 5'd5,  32'hC,        32'h8,        32'h11111111, 1, 8'hA0, 5'd5,  1, 1, 0, 0);
    vt[3]  = mk(1, 0, 32'h0,        32'h22222222, 8'h22, 5'd7,  32'hC,        32'h8,        32'h11111111, 1, 8'h00, 5'd0,  0, 0, 1, 0);
    vt[4]  = mk(0, 0, 32'h0,        32'h22222222, 8'h22, 5'd7,  32'h10,       32'hC,        32'h22222222, 1, 8'h22, 5'd7,  1, 0, 1, 0);
    vt[5]  = mk(1, 0, 32'h0,        32'h33333333, 8'hA0, 5'd9,  32'h10,       32'hC,        32'h22222222, 1, 8'h00, 5'd0,  0, 0, 2, 0);
    vt[6]  = mk(1, 0, 32'h0,        32'h33333333, 8'hA0, 5'd9,  32'h10,       32'hC,        32'h22222222, 1, 8'h00, 5'd0,  0, 0, 3, 0);
    vt[7]  = mk(1, 0, 32'h0,        32'h33333333, 8'hA0, 5'd9,  32'h10,       32'hC,        32'h22222222, 1, 8'h00, 5'd0,  0, 0, 4, 0);
    vt[8]  = mk(1, 1, 32'h103,      32'h44444444, 8'hA0, 5'd9,  32'h100,      32'h0,        32'h00000013, 0, 8'h00, 5'd0,  0, 0, 4, 1);
    vt[9]  = mk(0, 0, 32'h0,        32'h55555555, 8'hA0, 5'd10, 32'h104,      32'h100,      32'h55555555, 1, 8'h00, 5'd10, 0, 0, 4, 1);
    vt[10] = mk(0, 1, 32'hFFFFFFFF, 32'h55555555, 8'hA0, 5'd10, 32'hFFFFFFFC, 32'h0,        32'h00000013, 0, 8'h00, 5'd0,  0, 0, 4, 2);
    vt[11] = mk(0, 0, 32'h0,        32'h66666666, 8'hA0, 5'd11, 32'h0,        32'hFFFFFFFC, 32'h66666666, 1, 8'h00, 5'd11, 0, 0, 4, 2);
    vt[12] = mk(0, 0, 32'h0,        32'h77777777, 8'hA0, 5'd12, 32'h4,        32'h0,        32'h77777777, 1, 8'hA0, 5'd12, 1, 1, 4, 2);

    rst_n = 1'b0;
    rst_ns = 1'b0;
    bus.stall = 0; bus.flush = 0; bus.redirect_pc = 0; bus.imem_instr = 0;
    bus.id_ctrl = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0;
    bus_s.stall = 1; bus_s.flush = 0; bus_s.redirect_pc = 0; bus_s.imem_instr = 32'h13;
    bus_s.id_ctrl = 0; bus_s.id_rs1 = 0; bus_s.id_rs2 = 0; bus_s.id_rd = 0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_state("rst");

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      bus.stall       = vt[i].stall;
      bus.flush       = vt[i].flush;
      bus.redirect_pc = vt[i].redir;
      bus.imem_instr  = vt[i].instr;
      bus.id_ctrl     = vt[i].ctrl;
      bus.id_rd       = vt[i].rd;
      bus.id_rs1      = vt[i].rd + 5'd1;
      bus.id_rs2      = vt[i].rd + 5'd2;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_pc", i),       bus.pc, vt[i].e_pc);
      check($sformatf("v%0d_ifpc", i),     bus.if_id_pc, vt[i].e_ifpc);
      check($sformatf("v%0d_ifinstr", i),  bus.if_id_instr, vt[i].e_instr);
      check($sformatf("v%0d_ifvalid", i),  {31'h0, bus.if_id_valid}, {31'h0, vt[i].e_ifv});
      check($sformatf("v%0d_exctrl", i),   {24'h0, bus.id_ex_ctrl}, {24'h0, vt[i].e_ctrl});
      check($sformatf("v%0d_exrd", i),     {27'h0, bus.id_ex_rd}, {27'h0, vt[i].e_rd});
      check($sformatf("v%0d_exrs1", i),    {27'h0, bus.id_ex_rs1},
            (vt[i].e_rd == 5'd0) ? 32'h0 : {27'h0, vt[i].e_rd + 5'd1});
      check($sformatf("v%0d_exrs2", i),    {27'h0, bus.id_ex_rs2},
            (vt[i].e_rd == 5'd0) ? 32'h0 : {27'h0, vt[i].e_rd + 5'd2});
      check($sformatf("v%0d_exvalid", i),  {31'h0, bus.id_ex_valid}, {31'h0, vt[i].e_exv});
      check($sformatf("v%0d_memread", i),  {31'h0, bus.id_ex_mem_read}, {31'h0, vt[i].e_mr});
      check($sformatf("v%0d_stallcnt", i), {16'h0, bus.stall_cnt}, {16'h0, vt[i].e_sc});
      check($sformatf("v%0d_flushcnt", i), {16'h0, bus.flush_cnt}, {16'h0, vt[i].e_fc});
      @(negedge clk);
    end

    // async reset dropped mid-cycle while stalling
    bus.stall = 1; bus.flush = 0; bus.imem_instr = 32'h88888888;
    @(posedge clk);
    #1;
    check("pre_rst_stallcnt", {16'h0, bus.stall_cnt}, 32'h5);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("async");

    // a redirect presented during reset must not survive release
    @(negedge clk);
    bus.stall = 0; bus.flush = 1; bus.redirect_pc = 32'h200;
    @(posedge clk);
    #1;
    check("rst_hold_pc", bus.pc, 32'h0);
    @(negedge clk);
    bus.flush = 0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_pc", bus.pc, 32'h4);
    check("rel_ifinstr", bus.if_id_instr, 32'h88888888);
    check("rel_ifpc", bus.if_id_pc, 32'h0);
    check("rel_flushcnt", {16'h0, bus.flush_cnt}, 32'h0);

    // saturation on the narrow-counter instance, stall held from release
    @(negedge clk);
    rst_ns = 1'b1;
    repeat (14) @(posedge clk);
    #1;
    check("sat_cnt14", {28'h0, bus_s.stall_cnt}, 32'd14);
    @(posedge clk);
    #1;
    check("sat_cnt15", {28'h0, bus_s.stall_cnt}, 32'd15);
    repeat (5) @(posedge clk);
    #1;
    check("sat_hold", {28'h0, bus_s.stall_cnt}, 32'd15);
    check("sat_pc", bus_s.pc, 32'h0);
    check("sat_exvalid", {31'h0, bus_s.id_ex_valid}, 32'h0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Consumer side of the load-use stall and branch-flush signals in the 5-stage RV32I pipeline.
- Owns three registers: PC, IF/ID and the ID/EX control/tag slice.
- On stall it holds PC and IF/ID and injects a bubble into ID/EX. On flush it redirects the PC and kills the younger instructions.
- It also feeds ID_EX_rd and ID_EX_MemRead back to the hazard detector, and counts stall and flush events for performance monitoring.

Parameters:
- XLEN, 32, PC/instruction width.
- CTRL_W, 8, width of packed ID-stage control bundle {MemRead, MemWrite, RegWrite, MemToReg, ALUSrc, Branch, ALUOp[1:0]}; bit 7 = MemRead, bit 5 = RegWrite.
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INSTR, 32'h0000_0013, instruction placed in IF/ID on flush (addi x0,x0,0).
- CNT_W, 16, performance counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  load-use stall request from hazard detector (combinational, same cycle).
- flush  in  1  branch/jump taken, resolved in EX.
- redirect_pc  in  XLEN  branch/jump target, valid when flush=1.
- imem_instr  in  XLEN  instruction fetched at pc.
- id_ctrl  in  CTRL_W  decoder control bundle for instruction in IF/ID.
- id_rs1  in  5  rs1 of IF/ID instruction.
- id_rs2  in  5  rs2 of IF/ID instruction.
- id_rd  in  5  rd of IF/ID instruction.
- pc  out  XLEN  current fetch address.
- if_id_pc  out  XLEN  PC of instruction in IF/ID.
- if_id_instr  out  XLEN  instruction in IF/ID.
- if_id_valid  out  1  IF/ID holds a live instruction.
- id_ex_ctrl  out  CTRL_W  control bundle in ID/EX (all zero for a bubble).
- id_ex_rs1  out  5  registered rs1.
- id_ex_rs2  out  5  registered rs2.
- id_ex_rd  out  5  registered rd (to hazard detector).
- id_ex_mem_read  out  1  id_ex_ctrl[7] (to hazard detector).
- id_ex_valid  out  1  ID/EX holds a live instruction.
- stall_cnt  out  CNT_W  cycles with stall=1 and flush=0.
- flush_cnt  out  CNT_W  cycles with flush=1.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; if_id_pc=0; if_id_instr=NOP_INSTR; if_id_valid=0.
  - id_ex_ctrl=0; id_ex_rs1/rs2/rd=0; id_ex_valid=0; both counters=0.
  - Release is synchronous to the next rising edge. The first fetch is at RESET_PC.
- Per-edge action priority: flush > stall > normal.
- Normal (flush=0, stall=0):
  - pc <= pc+4.
  - IF/ID <= {pc, imem_instr, valid=1}.
  - ID/EX <= {id_ctrl, id_rs1, id_rs2, id_rd, valid=if_id_valid}. If if_id_valid=0, id_ex_ctrl <= 0.
- Stall (flush=0, stall=1):
  - pc and IF/ID hold their values.
  - ID/EX <= bubble: ctrl=0, rs1/rs2/rd=0, valid=0.
  - stall_cnt increments.
  - Latency: exactly one bubble per stall cycle. A stall held for N cycles produces N bubbles.
- Flush (flush=1, stall ignored):
  - pc <= redirect_pc.
  - IF/ID <= {0, NOP_INSTR, valid=0}.
  - ID/EX <= bubble.
  - flush_cnt increments.
  - The instruction after the flush edge fetches at redirect_pc.
- PC arithmetic: modulo 2^XLEN; 32'hFFFF_FFFC+4 wraps to 0. redirect_pc bits [1:0] are forced to 0.
- Counters saturate at all-ones; no wrap.
- id_ex_mem_read is a continuous assign of id_ex_ctrl[7]. It is therefore 0 in the cycle after a stall, which self-terminates a single load-use stall.
- A bubble never asserts RegWrite or MemWrite downstream (ctrl=0).
- Reset asserted mid-stall or mid-flush: all state returns immediately to reset values. No pending redirect survives.

Test Plan:
- Reset release, stall=0, flush=0, imem_instr=32'h00500093 -> pc sequence 0,4,8. One edge after release: if_id_instr=32'h00500093, if_id_valid=1, if_id_pc=0.
- lw x5 in ID/EX (id_ctrl bit7=1, id_rd=5), stall=1 for one cycle with pc=12 -> pc stays 12 and IF/ID holds. Next cycle: id_ex_ctrl=0, id_ex_valid=0, id_ex_mem_read=0, stall_cnt=1.
- stall=1 held for 3 cycles -> 3 consecutive bubbles, pc unchanged, stall_cnt=3.
- flush=1 and stall=1 same cycle, redirect_pc=32'h0000_0103 -> pc=32'h0000_0100, if_id_instr=32'h00000013, if_id_valid=0, id_ex_valid=0, flush_cnt=1, stall_cnt unchanged.
- pc=32'hFFFF_FFFC, no stall/flush -> pc=0 next edge.
- rst_n dropped asynchronously mid-cycle during stall -> all outputs at reset values before the next clk edge. Force stall_cnt to all-ones (CNT_W=4 build, i.e. 15) and stall again -> stays at 15.
